fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls instruction fetch from the instruction memory.
- Holds the program counter (PC) and drives the word address to the memory, whose read path is combinational.
- Registers each returned instruction into a fetch output stage with a valid/ready handshake toward decode.
- Handles stall back-pressure, branch/jump redirects with flush, start gating and end-of-program halt.

Parameters:
- PROG_LEN, 3, number of valid instruction words; the PC must stay below this value to fetch.
- PC_W, 32, width of the PC and of the memory address.
- CNT_W, 16, width of the retired-fetch counter.

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that leaves IDLE and begins fetching at PC 0.
- mem_addr  out  PC_W  word address to the instruction memory; equals the pc register, combinational.
- mem_instruction  in  32  instruction word returned by the memory in the same cycle.
- instr_out  out  32  registered instruction presented to decode.
- pc_out  out  PC_W  address that instr_out was fetched from.
- instr_valid  out  1  instr_out and pc_out are valid.
- instr_ready  in  1  decode accepts the output; a transfer occurs when instr_valid && instr_ready.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  PC_W  redirect target word address.
- halted  out  1  program finished and the output stage is empty.
- fetch_count  out  CNT_W  number of accepted transfers; saturates at all-ones.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE; pc=0.
  - instr_out=0, pc_out=0, instr_valid=0, halted=0, fetch_count=0.
  - Deassertion takes effect on the next clock edge; assertion aborts any operation in progress immediately.
- States:
  - IDLE: no fetch. start=1 → FETCH. Redirects are ignored.
  - FETCH: a fetch occurs when the output stage can load (load = !instr_valid || instr_ready) and pc < PROG_LEN. On a fetch, at the clock edge:
    - instr_out <= mem_instruction
    - pc_out <= pc
    - instr_valid <= 1
    - pc <= pc+1
  - FETCH when load=1 but pc >= PROG_LEN: instr_valid <= 0; go to HALT.
  - HALT: halted=1 while instr_valid=0. No memory fetch. Only a redirect or reset leaves HALT.
- Throughput and latency:
  - One instruction per cycle when instr_ready is held at 1.
  - First instr_valid appears 2 cycles after the start pulse: cycle 1 enters FETCH, cycle 2 registers the word for PC 0.
- Stall: while instr_valid=1 && instr_ready=0, the following hold stable and pc does not advance:
  - instr_out
  - pc_out
  - instr_valid
- Redirect (FETCH or HALT), in one cycle:
  - pc <= redirect_pc and instr_valid <= 0, flushing the output stage; no fetch occurs that cycle.
  - If a transfer (instr_valid && instr_ready) happens in the same cycle, it still counts; decode owns that word.
  - Next state is FETCH; it becomes HALT on the following cycle if redirect_pc >= PROG_LEN.
- Priority: reset > redirect > fetch/stall.
- Simultaneous start and redirect in IDLE: start wins and pc=0.
- PC arithmetic:
  - Unsigned, modulo 2^PC_W.
  - Any pc >= PROG_LEN is treated as end of program; the memory is never addressed out of range during a fetch.
- fetch_count:
  - Increments by 1 on every transfer.
  - Holds at 2^CNT_W-1.
  - Cleared only by reset.
- mem_addr always reflects pc, including in IDLE and HALT; the memory read is harmless.

Test Plan:
- Reset, start pulse, instr_ready=1, memory words W0..W2 → instr_valid on cycles 2,3,4 carrying pc_out 0,1,2 with W0,W1,W2; then instr_valid=0, halted=1, fetch_count=3.
- instr_ready=0 for 3 cycles after the first valid → instr_out=W0 and pc_out=0 held stable and mem_addr=1 unchanged; after release, W1 follows next cycle and fetch_count=3 at halt.
- redirect_valid with redirect_pc=0 while pc_out=1 is valid and instr_ready=1 → that word is counted; next cycle instr_valid=0; the following cycle pc_out=0 with W0.
- In HALT, redirect_pc=2 → exactly one more transfer of W2, then halted=1 again; redirect_pc=5 in HALT → halted=1 again after one cycle and no valid output.
- reset_n pulsed low mid-stream, asynchronously between edges → all outputs 0 immediately and state IDLE; no fetch until a new start.
- start and redirect_valid (redirect_pc=2) asserted together in IDLE → first fetched pc_out=0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer.
// Holds the PC and addresses a combinational instruction memory. Each
// returned word is registered into a valid/ready output stage toward decode.
// Also handles stall back-pressure, redirect with flush, start gating and
// end-of-program halt.
//
// Ports:
//   clock, reset_n      rising-edge clock, async active-low reset
//   start               one-cycle pulse: leave IDLE, fetch from PC 0
//   mem_addr            word address to memory (combinational, equals pc)
//   mem_instruction     word returned by memory in the same cycle
//   instr_out, pc_out   registered instruction and the address it came from
//   instr_valid         output stage holds a word
//   instr_ready         decode accepts the word this cycle
//   redirect_valid/pc   taken branch/jump and its target word address
//   halted              program finished and output stage empty
//   fetch_count         accepted transfers, saturating
module fetch_sequencer #(
  parameter int unsigned PROG_LEN = 3,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  output logic [PC_W-1:0]  mem_addr,
  input  logic [31:0]      mem_instruction,
  output logic [31:0]      instr_out,
  output logic [PC_W-1:0]  pc_out,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int unsigned INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [PC_W-1:0]    pc, pc_d;
  logic [INSTR_W-1:0] instr_d;
  logic [PC_W-1:0]    pc_out_d;
  logic               valid_d;
  logic               halted_d;
  logic [CNT_W-1:0]   count_d;

  logic transfer_c;
  logic load_c;
  logic in_range_c;

  assign mem_addr   = pc;
  assign transfer_c = instr_valid && instr_ready;
  // Output stage can take a new word when empty or being drained this cycle.
  assign load_c     = !instr_valid || instr_ready;
  assign in_range_c = pc < PC_W'(PROG_LEN);

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= '0;
      instr_out   <= '0;
      pc_out      <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      instr_out   <= instr_d;
      pc_out      <= pc_out_d;
      instr_valid <= valid_d;
      halted      <= halted_d;
      fetch_count <= count_d;
    end
  end

  // Next-state and next-output logic; redirect outranks fetch and stall.
  always_comb begin
    state_d  = state;
    pc_d     = pc;
    instr_d  = instr_out;
    pc_out_d = pc_out;
    valid_d  = instr_valid;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          pc_d    = '0;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (load_c) begin
          if (in_range_c) begin
            instr_d  = mem_instruction;
            pc_out_d = pc;
            valid_d  = 1'b1;
            pc_d     = pc + PC_W'(1);
          end else begin
            valid_d = 1'b0;
            state_d = HALT;
          end
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered so that halted tracks HALT with an empty output stage.
    halted_d = (state_d == HALT) && !valid_d;

    // A transfer in a redirect cycle still counts; decode owns that word.
    count_d = fetch_count;
    if (transfer_c && (fetch_count != {CNT_W{1'b1}})) begin
      count_d = fetch_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: per-cycle vector tables plus a transfer
// scoreboard fed with the expected {pc, word} sequence of each scenario.
module tb_fetch_sequencer;

  localparam int unsigned PROG_LEN = 3;
  localparam int unsigned PC_W     = 32;
  localparam int unsigned CNT_W    = 16;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [PC_W-1:0]  mem_addr;
  logic [31:0]      mem_instruction;
  logic [31:0]      instr_out;
  logic [PC_W-1:0]  pc_out;
  logic             instr_valid;
  logic             instr_ready;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;

  fetch_sequencer #(
    .PROG_LEN(PROG_LEN),
    .PC_W    (PC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .mem_addr       (mem_addr),
    .mem_instruction(mem_instruction),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'd0:   return 32'hA000_0000;
      32'd1:   return 32'hA111_1111;
      32'd2:   return 32'hA222_2222;
      default: return 32'hBAD0_BAD0;
    endcase
  endfunction

  // Combinational instruction memory.
  always_comb mem_instruction = word_at(mem_addr);

  typedef struct {
    logic        start;
    logic        ready;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_halted;
    logic [31:0] exp_addr;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks;
  int   n_fail;

  function automatic vec_t mk(input logic s, input logic r, input logic rv,
                              input logic [31:0] rpc, input logic ev,
                              input logic [31:0] epc, input logic eh,
                              input logic [31:0] ea);
    vec_t v;
    v.start = s; v.ready = r; v.rv = rv; v.rpc = rpc;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_halted = eh; v.exp_addr = ea;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = word_at(pc);
    sb.push_back(e);
  endtask

  // One clock: at the negedge, score any transfer about to happen; return
  // 1 time unit after the following rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clock);
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_transfer_pc", pc_out, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_pc_out", pc_out, e.pc);
        chk("sb_instr_out", instr_out, e.instr);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_instr_out"},   instr_out, 32'd0);
    chk({tag, "_pc_out"},      pc_out, 32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_halted"},      32'(halted), 32'd0);
    chk({tag, "_fetch_count"}, 32'(fetch_count), 32'd0);
    chk({tag, "_mem_addr"},    mem_addr, 32'd0);
  endtask

  task automatic do_reset();
    start          = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    reset_n        = 1'b0;
    #1;
    chk_zero_outputs("reset");
    sb.delete();
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      start          = tbl[i].start;
      instr_ready    = tbl[i].ready;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      cycle();
      chk($sformatf("%s_v%0d_valid", tag, i), 32'(instr_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("%s_v%0d_pc_out", tag, i), pc_out, tbl[i].exp_pc);
        chk($sformatf("%s_v%0d_instr", tag, i), instr_out, word_at(tbl[i].exp_pc));
      end
      chk($sformatf("%s_v%0d_halted", tag, i), 32'(halted), 32'(tbl[i].exp_halted));
      chk($sformatf("%s_v%0d_mem_addr", tag, i), mem_addr, tbl[i].exp_addr);
    end
    tbl.delete();
    start          = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Straight-line run, ready held high.
    do_reset();
    push_exp(0); push_exp(1); push_exp(2);
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2, 0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3));
    run_tbl("run");
    chk("run_fetch_count", 32'(fetch_count), 32'd3);
    chk("run_sb_drain", 32'(sb.size()), 32'd0);

    // Stall: ready low for three cycles while the first word is valid.
    do_reset();
    push_exp(0); push_exp(1); push_exp(2);
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2, 0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3));
    run_tbl("stall");
    chk("stall_fetch_count", 32'(fetch_count), 32'd3);
    chk("stall_sb_drain", 32'(sb.size()), 32'd0);

    // Redirect with concurrent transfer, then redirects out of HALT.
    do_reset();
    push_exp(0); push_exp(1);
    push_exp(0); push_exp(1); push_exp(2);
    push_exp(2);
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2, 0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(0, 1, 1, 2, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2, 0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3));
    tbl.push_back(mk(0, 1, 1, 5, 0, 0, 0, 5));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 5));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 5));
    run_tbl("redir");
    chk("redir_fetch_count", 32'(fetch_count), 32'd6);
    chk("redir_sb_drain", 32'(sb.size()), 32'd0);

    // Asynchronous reset mid-stream, between clock edges.
    do_reset();
    push_exp(0); push_exp(1);
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 2));
    run_tbl("pre_rst");
    #3;
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("mid_rst");
    sb.delete();
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    run_tbl("post_rst_idle");
    chk("post_rst_count", 32'(fetch_count), 32'd0);
    push_exp(0); push_exp(1); push_exp(2);
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2, 0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3));
    run_tbl("post_rst_run");
    chk("post_rst_run_count", 32'(fetch_count), 32'd3);

    // Start and redirect together in IDLE: start wins, fetch begins at 0.
    do_reset();
    push_exp(0); push_exp(1); push_exp(2);
    tbl.push_back(mk(1, 1, 1, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2, 0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 3));
    run_tbl("start_redir");
    chk("start_redir_count", 32'(fetch_count), 32'd3);
    chk("start_redir_sb_drain", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
